// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the ID-stage decoder and pipe_ctrl.
// The master side drives decoded ID fields and pipe status; the slave side
// (pipe_ctrl) returns stall, bubble, flush, forwarding selects and the
// stall counter.
interface pipe_ctrl_if #(
   parameter int STALL_CNT_W = 32
);
   logic                   id_valid_i;
   logic [4:0]             id_rs1_i;
   logic [4:0]             id_rs2_i;
   logic                   id_use_rs1_i;
   logic                   id_use_rs2_i;
   logic [4:0]             id_rd_i;
   logic                   id_wr_i;
   logic                   id_is_load_i;
   logic                   ex_branch_taken_i;
   logic                   mem_busy_i;
   logic                   pc_stall_o;
   logic                   if_id_stall_o;
   logic                   id_ex_bubble_o;
   logic                   flush_o;
   logic [1:0]             fwd_a_o;
   logic [1:0]             fwd_b_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_wr_i, id_is_load_i, ex_branch_taken_i, mem_busy_i,
      input  pc_stall_o, if_id_stall_o, id_ex_bubble_o, flush_o,
             fwd_a_o, fwd_b_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_wr_i, id_is_load_i, ex_branch_taken_i, mem_busy_i,
      output pc_stall_o, if_id_stall_o, id_ex_bubble_o, flush_o,
             fwd_a_o, fwd_b_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rv32i pipeline controller. Tracks the destinations of instructions in
// EX/MEM/WB in a 3-slot scoreboard, detects RAW / load-use hazards against
// the ID instruction and drives stall, bubble, flush and forwarding selects.
// Control outputs are combinational from the scoreboard and ID fields so the
// stage registers see them in the same cycle; only the stall counter is
// a register.
module pipe_ctrl #(
   parameter bit FWD_EN      = 1'b1,
   parameter int STALL_CNT_W = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   pipe_ctrl_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       is_load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, is_load: 1'b0};
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   slot_t                  ex_r, mem_r, wb_r;
   slot_t                  id_slot_s;
   logic [STALL_CNT_W-1:0] stall_cnt_r;
   logic                   load_use_s, any_match_s, hazard_s;
   logic                   pc_stall_s, if_id_stall_s, bubble_s, flush_s;
   logic [1:0]             fwd_a_s, fwd_b_s;

   // A slot only matters when it will actually write a non-x0 register.
   function automatic logic slot_writer(input slot_t s);
      return s.valid & s.wr & (s.rd != 5'd0);
   endfunction

   function automatic logic slot_match(input slot_t s, input logic [4:0] rs,
                                       input logic use_rs);
      return slot_writer(s) & (s.rd == rs) & (rs != 5'd0) & use_rs;
   endfunction

   // Youngest producer wins: EX, then MEM, then WB, else register file.
   function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                          input slot_t wb, input logic [4:0] rs,
                                          input logic use_rs);
      logic [1:0] sel;
      if (slot_match(ex, rs, use_rs)) begin
         sel = 2'd1;
      end else if (slot_match(mem, rs, use_rs)) begin
         sel = 2'd2;
      end else if (slot_match(wb, rs, use_rs)) begin
         sel = 2'd3;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   assign id_slot_s = '{valid: 1'b1, rd: bus.id_rd_i, wr: bus.id_wr_i,
                        is_load: bus.id_is_load_i};

   // Hazard detection: load-use only with forwarding, any RAW without.
   always_comb begin
      load_use_s  = ex_r.is_load &
                    (slot_match(ex_r, bus.id_rs1_i, bus.id_use_rs1_i) |
                     slot_match(ex_r, bus.id_rs2_i, bus.id_use_rs2_i));
      any_match_s = slot_match(ex_r,  bus.id_rs1_i, bus.id_use_rs1_i) |
                    slot_match(ex_r,  bus.id_rs2_i, bus.id_use_rs2_i) |
                    slot_match(mem_r, bus.id_rs1_i, bus.id_use_rs1_i) |
                    slot_match(mem_r, bus.id_rs2_i, bus.id_use_rs2_i) |
                    slot_match(wb_r,  bus.id_rs1_i, bus.id_use_rs1_i) |
                    slot_match(wb_r,  bus.id_rs2_i, bus.id_use_rs2_i);
      if (FWD_EN) begin
         hazard_s = bus.id_valid_i & load_use_s;
      end else begin
         hazard_s = bus.id_valid_i & any_match_s;
      end
   end

   // Operand forwarding selects; tied to register file without forwarding.
   always_comb begin
      if (FWD_EN) begin
         fwd_a_s = fwd_sel(ex_r, mem_r, wb_r, bus.id_rs1_i, bus.id_use_rs1_i);
         fwd_b_s = fwd_sel(ex_r, mem_r, wb_r, bus.id_rs2_i, bus.id_use_rs2_i);
      end else begin
         fwd_a_s = 2'd0;
         fwd_b_s = 2'd0;
      end
   end

   // Per-cycle control priority: memory freeze, branch flush, hazard stall.
   always_comb begin
      pc_stall_s    = 1'b0;
      if_id_stall_s = 1'b0;
      bubble_s      = 1'b0;
      flush_s       = 1'b0;
      if (bus.mem_busy_i) begin
         pc_stall_s    = 1'b1;
         if_id_stall_s = 1'b1;
      end else if (bus.ex_branch_taken_i) begin
         flush_s  = 1'b1;
         bubble_s = 1'b1;
      end else if (hazard_s) begin
         pc_stall_s    = 1'b1;
         if_id_stall_s = 1'b1;
         bubble_s      = 1'b1;
      end else begin
         pc_stall_s    = 1'b0;
         if_id_stall_s = 1'b0;
      end
   end

   // Scoreboard shift: frozen while memory is busy, bubble inserts an empty slot.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_r  <= SLOT_EMPTY;
         mem_r <= SLOT_EMPTY;
         wb_r  <= SLOT_EMPTY;
      end else if (!bus.mem_busy_i) begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         if (bus.id_valid_i && !bubble_s) begin
            ex_r <= id_slot_s;
         end else begin
            ex_r <= SLOT_EMPTY;
         end
      end else begin
         ex_r  <= ex_r;
         mem_r <= mem_r;
         wb_r  <= wb_r;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_r <= '0;
      end else if (pc_stall_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.pc_stall_o     = pc_stall_s;
   assign bus.if_id_stall_o  = if_id_stall_s;
   assign bus.id_ex_bubble_o = bubble_s;
   assign bus.flush_o        = flush_s;
   assign bus.fwd_a_o        = fwd_a_s;
   assign bus.fwd_b_o        = fwd_b_s;
   assign bus.stall_cnt_o    = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one forwarding instance (32-bit counter) and one
// non-forwarding instance (2-bit counter to reach saturation). Stimulus
// pushes hand-computed expectations into a queue; a negedge monitor pops
// and compares them against the addressed instance.
module tb_pipe_ctrl;

   logic clk;
   logic rst;

   pipe_ctrl_if #(.STALL_CNT_W(32)) if_a ();
   pipe_ctrl_if #(.STALL_CNT_W(2))  if_b ();

   pipe_ctrl #(.FWD_EN(1'b1), .STALL_CNT_W(32)) u_fwd (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_a)
   );

   pipe_ctrl #(.FWD_EN(1'b0), .STALL_CNT_W(2)) u_nofwd (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          d;
      logic        pc;
      logic        ifid;
      logic        bub;
      logic        fl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      bit          cf;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   errors = 0;
   int   checks = 0;
   logic        a_pc, a_ifid, a_bub, a_fl;
   logic [1:0]  a_fa, a_fb;
   logic [31:0] a_cnt;
   logic        bad;

   // Monitor: compare every pending expectation against the DUT outputs.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         cur = sb.pop_front();
         if (cur.d == 0) begin
            a_pc = if_a.pc_stall_o; a_ifid = if_a.if_id_stall_o;
            a_bub = if_a.id_ex_bubble_o; a_fl = if_a.flush_o;
            a_fa = if_a.fwd_a_o; a_fb = if_a.fwd_b_o; a_cnt = if_a.stall_cnt_o;
         end else begin
            a_pc = if_b.pc_stall_o; a_ifid = if_b.if_id_stall_o;
            a_bub = if_b.id_ex_bubble_o; a_fl = if_b.flush_o;
            a_fa = if_b.fwd_a_o; a_fb = if_b.fwd_b_o;
            a_cnt = {30'd0, if_b.stall_cnt_o};
         end
         bad = (a_pc !== cur.pc) || (a_ifid !== cur.ifid) || (a_bub !== cur.bub) ||
               (a_fl !== cur.fl) || (a_cnt !== cur.cnt) ||
               (cur.cf && ((a_fa !== cur.fa) || (a_fb !== cur.fb)));
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s: got pc=%0b ifid=%0b bub=%0b fl=%0b fa=%0d fb=%0d cnt=%0d, need pc=%0b ifid=%0b bub=%0b fl=%0b fa=%0d fb=%0d (fwd checked=%0b) cnt=%0d",
                     cur.name, a_pc, a_ifid, a_bub, a_fl, a_fa, a_fb, a_cnt,
                     cur.pc, cur.ifid, cur.bub, cur.fl, cur.fa, cur.fb, cur.cf, cur.cnt);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if_a.id_valid_i = 1'b0; if_a.id_rs1_i = 5'd0; if_a.id_rs2_i = 5'd0;
      if_a.id_use_rs1_i = 1'b0; if_a.id_use_rs2_i = 1'b0; if_a.id_rd_i = 5'd0;
      if_a.id_wr_i = 1'b0; if_a.id_is_load_i = 1'b0;
      if_a.ex_branch_taken_i = 1'b0; if_a.mem_busy_i = 1'b0;
      if_b.id_valid_i = 1'b0; if_b.id_rs1_i = 5'd0; if_b.id_rs2_i = 5'd0;
      if_b.id_use_rs1_i = 1'b0; if_b.id_use_rs2_i = 1'b0; if_b.id_rd_i = 5'd0;
      if_b.id_wr_i = 1'b0; if_b.id_is_load_i = 1'b0;
      if_b.ex_branch_taken_i = 1'b0; if_b.mem_busy_i = 1'b0;
   endtask

   // Drive one instance's ID/status inputs; the other instance idles.
   task automatic drive(input int d, input bit v, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                        input bit wr, input bit ld, input bit br, input bit busy);
      idle_all();
      if (d == 0) begin
         if_a.id_valid_i = v; if_a.id_rs1_i = rs1; if_a.id_use_rs1_i = u1;
         if_a.id_rs2_i = rs2; if_a.id_use_rs2_i = u2; if_a.id_rd_i = rd;
         if_a.id_wr_i = wr; if_a.id_is_load_i = ld;
         if_a.ex_branch_taken_i = br; if_a.mem_busy_i = busy;
      end else begin
         if_b.id_valid_i = v; if_b.id_rs1_i = rs1; if_b.id_use_rs1_i = u1;
         if_b.id_rs2_i = rs2; if_b.id_use_rs2_i = u2; if_b.id_rd_i = rd;
         if_b.id_wr_i = wr; if_b.id_is_load_i = ld;
         if_b.ex_branch_taken_i = br; if_b.mem_busy_i = busy;
      end
   endtask

   task automatic expect_out(input string n, input int d, input bit pc, input bit ifid,
                             input bit bub, input bit fl, input logic [1:0] fa,
                             input logic [1:0] fb, input bit cf, input logic [31:0] cnt);
      exp_t e;
      e.name = n; e.d = d; e.pc = pc; e.ifid = ifid; e.bub = bub; e.fl = fl;
      e.fa = fa; e.fb = fb; e.cf = cf; e.cnt = cnt;
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b0;
      idle_all();
      cyc();
      expect_out("reset_a", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      expect_out("reset_b", 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      expect_out("idle10_a", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      expect_out("idle10_b", 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);

      // Forwarding distance EX -> MEM -> WB -> regfile
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0);
      expect_out("wr_x5", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      cyc(); drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("fwd_ex", 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 32'd0);
      cyc();
      expect_out("fwd_mem", 0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 32'd0);
      cyc();
      expect_out("fwd_wb", 0, 0, 0, 0, 0, 2'd3, 2'd0, 1, 32'd0);
      cyc();
      expect_out("fwd_rf", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);

      // Load-use: one bubble then MEM forwarding
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0);
      expect_out("lw_x7", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      cyc(); drive(0, 1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0, 0);
      expect_out("load_use_stall", 0, 1, 1, 1, 0, 2'd0, 2'd0, 0, 32'd0);
      cyc();
      expect_out("load_use_fwd_mem", 0, 0, 0, 0, 0, 2'd0, 2'd2, 1, 32'd1);
      cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("idle_after_lu", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);

      // x0 never forwards; EX beats MEM
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
      expect_out("wr_x0", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc(); drive(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
      expect_out("rd_x0", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
      expect_out("wr_x3_1", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc();
      expect_out("wr_x3_2", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc(); drive(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("ex_prio", 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 32'd1);

      // Branch overrides an active load-use hazard
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0);
      expect_out("lw_x8", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc(); drive(0, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      expect_out("branch_flush", 0, 0, 0, 1, 1, 2'd0, 2'd0, 0, 32'd1);
      cyc(); drive(0, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("ex_empty_after_flush", 0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 32'd1);

      // Memory freeze with writer x9 in EX; branch ignored while busy
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0);
      expect_out("wr_x9", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
      expect_out("busy1", 0, 1, 1, 0, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc();
      expect_out("busy2", 0, 1, 1, 0, 0, 2'd0, 2'd0, 1, 32'd2);
      cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
      expect_out("busy3_branch_ignored", 0, 1, 1, 0, 0, 2'd0, 2'd0, 1, 32'd3);
      cyc(); drive(0, 1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("frozen_ex_x9", 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 32'd4);
      cyc();
      expect_out("x9_fwd_mem", 0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 32'd4);

      // No forwarding: three stall cycles, then saturating 2-bit counter
      cyc(); drive(1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0);
      expect_out("nf_wr_x4", 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      cyc(); drive(1, 1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("nf_stall_ex", 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 32'd0);
      cyc();
      expect_out("nf_stall_mem", 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 32'd1);
      cyc();
      expect_out("nf_stall_wb", 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 32'd2);
      cyc();
      expect_out("nf_go", 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd3);
      cyc(); drive(1, 1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 0, 0);
      expect_out("nf_wr_x11", 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd3);
      cyc(); drive(1, 1, 5'd0, 0, 5'd11, 1, 5'd0, 0, 0, 0, 0);
      expect_out("nf_sat1", 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 32'd3);
      cyc();
      expect_out("nf_sat2", 1, 1, 1, 1, 0, 2'd0, 2'd0, 1, 32'd3);

      // Reset mid-operation clears scoreboard and counter immediately
      cyc(); drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 0, 0);
      expect_out("wr_x6", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd4);
      cyc();
      rst = 1'b0;
      drive(0, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      expect_out("mid_reset", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      cyc();
      expect_out("no_stale_fwd", 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 32'd0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, need 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline controller for the rv32i core; sequences the IF/ID/EX/MEM/WB datapath. It tracks destination registers of instructions in flight in EX, MEM and WB in a 3-slot scoreboard. It detects RAW and load-use hazards against the instruction in ID and drives stall, bubble, flush and operand-forwarding selects. Sits beside the stage modules at the rv32i top level; the decoder feeds it, and the EX operand muxes and pipeline registers consume its outputs.

Parameters:
FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard stalls until the producer has left WB
STALL_CNT_W, 32, width of the stall performance counter

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous reset, active-low
id_valid_i  input  1  ID holds a valid instruction
id_rs1_i  input  5  ID source register 1
id_rs2_i  input  5  ID source register 2
id_use_rs1_i  input  1  ID instruction reads rs1
id_use_rs2_i  input  1  ID instruction reads rs2
id_rd_i  input  5  ID destination register
id_wr_i  input  1  ID instruction writes rd
id_is_load_i  input  1  ID instruction is a load
ex_branch_taken_i  input  1  branch/jump resolved taken in EX
mem_busy_i  input  1  data memory not ready; freeze whole pipe
pc_stall_o  output  1  hold PC
if_id_stall_o  output  1  hold IF/ID register
id_ex_bubble_o  output  1  load NOP into ID/EX
flush_o  output  1  kill IF/ID contents (wrong-path)
fwd_a_o  output  2  operand1 select: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
fwd_b_o  output  2  operand2 select, same encoding
stall_cnt_o  output  STALL_CNT_W  count of cycles with pc_stall_o=1

Behaviour:
- Scoreboard: slots EX, MEM, WB; each holds {valid, rd, wr, is_load}. A slot counts as a writer only if valid & wr & rd!=0.
- Reset (rst_i=0, async): all slots invalid, stall_cnt_o=0. All control outputs are combinational; with slots invalid and no ID instruction, every output reads 0.
- Match(stage, rs): slot is a writer, rd==rs, rs!=0, and the corresponding use bit is set.
- Load-use hazard: the EX slot is_load and matches rs1 or rs2.
- FWD_EN=1:
  - hazard = id_valid_i & load-use.
  - fwd per operand, priority EX(1) > MEM(2) > WB(3) > 0.
  - A load in MEM may be forwarded (2).
  - With hazard=1, fwd outputs are don't-care.
- FWD_EN=0:
  - hazard = id_valid_i & any match in EX, MEM or WB.
  - fwd_a_o and fwd_b_o are held at 0.
- Per-cycle priority, highest first:
  1. mem_busy_i=1: pc_stall_o=if_id_stall_o=1, bubble=0, flush=0, slots hold. ex_branch_taken_i is ignored; EX holds the branch, so it is re-sampled on the cycle after mem_busy_i drops.
  2. ex_branch_taken_i=1: flush_o=1, id_ex_bubble_o=1, stalls=0. This overrides any hazard.
  3. hazard: pc_stall_o=if_id_stall_o=1, id_ex_bubble_o=1.
  4. Otherwise all 0.
- Slot update on clk_i rising edge, when mem_busy_i=0:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid_i & !bubble, else EX<=invalid.
- Load-use latency: exactly 1 bubble cycle, then forward from MEM.
- FWD_EN=0 worst case: 3 stall cycles when the producer has just entered EX.
- stall_cnt_o increments each clock with pc_stall_o=1 and saturates at all-ones.
- Simultaneous branch and hazard in the same cycle: flush wins; the hazard instruction is discarded, no stall.
- Reset asserted mid-operation clears the slots immediately; no stale forwarding after deassert.

Test Plan:
- Reset then idle: all outputs 0; stall_cnt_o=0 after 10 idle cycles.
- FWD_EN=1: issue add x5 (wr), then next cycle add rs1=x5 -> fwd_a_o=1 and no stall. One cycle later, same rs1 -> fwd_a_o=2. Next -> 3, then 0.
- FWD_EN=1: lw x7, then add rs2=x7 -> 1 cycle with pc_stall_o=if_id_stall_o=id_ex_bubble_o=1. Next cycle fwd_b_o=2, stall_cnt_o=1.
- Writer rd=x0 followed by reader rs1=x0 -> no stall, fwd_a_o=0. EX=x3 and MEM=x3 both writers -> fwd=1 (EX priority).
- ex_branch_taken_i=1 while the load-use hazard is active -> flush_o=1, bubble=1, stalls=0, EX slot invalid next cycle.
- mem_busy_i=1 for 3 cycles with a writer x9 in EX -> stalls held, slots frozen, stall_cnt_o +3. Afterwards a reader of x9 sees fwd=2. FWD_EN=0 variant: reader stalls 3 cycles after a fresh writer.
